// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: sequencer states and major-opcode constants shared with the control decoder.
package cpu_seq_pkg;
  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC1 = 3'd1,
    S_EXEC2 = 3'd2,
    S_EXEC3 = 3'd3,
    S_MWAIT = 3'd4,
    S_HALT  = 3'd5
  } state_e;
  localparam logic [3:0] OP_LDA  = 4'b0000;
  localparam logic [3:0] OP_STA  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_LDN  = 4'b1001;
  localparam logic [3:0] OP_SSS  = 4'b1010;
  localparam logic [3:0] OP_JZ   = 4'b1011;
  localparam logic [3:0] OP_JN   = 4'b1100;
  localparam logic [3:0] OP_CALL = 4'b1101;
  localparam logic [3:0] OP_NOT  = 4'b1110;
  localparam logic [3:0] OP_RET  = 4'b1111;
  localparam logic [3:0] SUB_STP = 4'b0000;
endpackage

// File: rtl/cpu_seq_waitctr.sv
// cpu_seq_waitctr: loadable 4-bit down-counter with zero flag, timing multiplier wait cycles.
module cpu_seq_waitctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] din,
  output logic       zero
);
  logic [3:0] cnt;
  assign zero = cnt == 4'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= 4'd0;
    else if (load) cnt <= din;
    else if (dec && !zero) cnt <= cnt - 4'd1;
endmodule

// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: FETCH/EXEC1-3 phase sequencer with multiplier wait, STP halt and retire count.
// Define CPU_SEQ_RESUME_EN to add a resume input that leaves HALT without reset.
module cpu_phase_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int MUL_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic [7:0]       IR_opcode,
  input  logic             mem_ready,
`ifdef CPU_SEQ_RESUME_EN
  input  logic             resume,
`endif
  output logic             IR_load,
  output logic             FETCH,
  output logic             EXEC1,
  output logic             EXEC2,
  output logic             EXEC3,
  output logic [3:0]       IR_oldopcode,
  output logic             MUL_busy,
  output logic             HALT,
  output logic [CNT_W-1:0] instr_count
);
  localparam logic [3:0] MW_LOAD = MUL_WAIT > 0 ? 4'(MUL_WAIT - 1) : 4'd0;
  logic [2:0] state, nxt;
  logic [3:0] major;
  logic       wz, go;
  assign major = IR_opcode[7:4];
`ifdef CPU_SEQ_RESUME_EN
  assign go = resume;
`else
  assign go = 1'b0;
`endif
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH: nxt = mem_ready ? S_EXEC1 : S_FETCH;
      S_EXEC1: nxt = (major == OP_LDN || major == OP_RET) ? S_EXEC2 :
                     (major == OP_MUL && MUL_WAIT > 0) ? S_MWAIT :
                     (major == OP_SSS && IR_opcode[3:0] == SUB_STP) ? S_HALT : S_FETCH;
      S_EXEC2: nxt = IR_oldopcode == OP_LDN ? S_EXEC3 : S_FETCH;
      S_EXEC3: nxt = S_FETCH;
      S_MWAIT: nxt = wz ? S_FETCH : S_MWAIT;
      S_HALT:  nxt = go ? S_FETCH : S_HALT;
      default: nxt = S_FETCH;
    endcase
  end
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      state        <= S_FETCH;
      IR_oldopcode <= 4'd0;
      instr_count  <= '0;
    end else begin
      state <= nxt;
      if (state == S_EXEC1) begin
        IR_oldopcode <= major;
        instr_count  <= instr_count + CNT_W'(1);
      end
    end
  // Loaded with MUL_WAIT-1 so the zero test ends the dwell after exactly MUL_WAIT cycles.
  cpu_seq_waitctr u_waitctr (
    .clk  (CLK),
    .rst_n(nRESET),
    .load (state == S_EXEC1 && nxt == S_MWAIT),
    .dec  (state == S_MWAIT),
    .din  (MW_LOAD),
    .zero (wz)
  );
  assign FETCH    = state == S_FETCH;
  assign IR_load  = FETCH & mem_ready;
  assign EXEC1    = state == S_EXEC1;
  assign EXEC2    = state == S_EXEC2;
  assign EXEC3    = state == S_EXEC3;
  assign MUL_busy = state == S_MWAIT;
  assign HALT     = state == S_HALT;
endmodule

// File: doc/cpu_phase_sequencer.md
Name: cpu_phase_sequencer

Overview:
- Sequences the instruction phases of the accumulator CPU.
- Generates the one-hot FETCH/EXEC1/EXEC2/EXEC3 strobes that qualify the address/control decoder, loads the IR, and keeps the previous-instruction opcode register (IR_oldopcode).
- Inserts multiplier wait cycles, halts on STP, and counts retired instructions.
- Sits between the IR/memory and the combinational control decoder.

Parameters:
- MUL_WAIT, 2: extra idle cycles after EXEC1 of MUL; range 0..15.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- CLK  input  1  system clock, rising edge
- nRESET  input  1  asynchronous, active-low reset
- IR_opcode  input  8  current IR opcode byte; bits 7:4 are the major opcode, bits 3:0 are the SSS sub-op
- mem_ready  input  1  instruction memory data valid; FETCH stalls while low
- IR_load  output  1  IR capture strobe
- FETCH  output  1  fetch phase
- EXEC1  output  1  execute phase 1
- EXEC2  output  1  execute phase 2
- EXEC3  output  1  execute phase 3
- IR_oldopcode  output  4  major opcode of the last instruction to leave EXEC1
- MUL_busy  output  1  multiplier wait in progress
- HALT  output  1  processor stopped by STP
- instr_count  output  CNT_W  instructions retired (EXEC1 entries)

Behaviour:
- States: S_FETCH, S_EXEC1, S_EXEC2, S_EXEC3, S_MWAIT, S_HALT. State is registered; all strobes are Moore outputs decoded from state.
- Reset (async, nRESET=0): state=S_FETCH, IR_oldopcode=0, instr_count=0, wait counter=0. FETCH=1 immediately; all other outputs 0.
- S_FETCH: FETCH=1; IR_load=mem_ready (combinational AND with state). If mem_ready=1, go to S_EXEC1; otherwise hold with IR_load=0.
- S_EXEC1: EXEC1=1 for exactly one cycle. instr_count increments modulo 2^CNT_W. IR_oldopcode<=IR_opcode[7:4] at the end of the cycle. Next state by opcode:
  - LDN (1001) -> S_EXEC2
  - RET (1111) -> S_EXEC2
  - MUL (0100) with MUL_WAIT>0 -> S_MWAIT, load counter with MUL_WAIT-1
  - STP (SSS sub-op 0000, i.e. opcode 0xA0) -> S_HALT
  - everything else, including MUL with MUL_WAIT=0 -> S_FETCH
- S_EXEC2: EXEC2=1. If IR_oldopcode==LDN, go to S_EXEC3; otherwise (RET) go to S_FETCH.
- S_EXEC3: EXEC3=1 for one cycle, then S_FETCH.
- S_MWAIT: MUL_busy=1 and no phase strobe. Counter decrements; when the counter is 0, go to S_FETCH. Total MWAIT dwell is exactly MUL_WAIT cycles.
- S_HALT: HALT=1 and all strobes 0. Exit only via reset, or via resume (see optional feature).
- IR is stable outside FETCH. mem_ready is ignored in every state except S_FETCH.
- Exactly one of FETCH/EXEC1/EXEC2/EXEC3 is high in fetch/exec states; none is high in S_MWAIT or S_HALT.
- Reset asserted mid-instruction aborts it immediately. No strobe glitches: all outputs are decoded from state.
- Illegal or unused state encodings recover to S_FETCH on the next cycle.

Optional Feature:
- Macro CPU_SEQ_RESUME_EN.
- Defined: adds input resume (1 bit). In S_HALT, resume=1 moves to S_FETCH on the next edge. HALT is deasserted in that cycle and instr_count is unchanged.
- Undefined: no resume port; S_HALT is terminal until nRESET.

Decomposition:
- Package cpu_seq_pkg holds:
  - state enum (3-bit encoding)
  - 4-bit major-opcode localparams: OP_LDA..OP_RET, with OP_LDN=4'b1001, OP_MUL=4'b0100, OP_SSS=4'b1010, OP_RET=4'b1111
  - SUB_STP=4'b0000
- The opcode constants are shared with the control decoder.
- One natural sub-module: cpu_seq_waitctr, a loadable 4-bit down-counter with a zero flag used for S_MWAIT.

Test Plan:
- Reset, then LDA (0x00) with mem_ready=1 -> FETCH,EXEC1,FETCH; instr_count=1; IR_oldopcode=0000.
- LDN (0x90) -> FETCH,EXEC1,EXEC2,EXEC3,FETCH (4 cycles); IR_oldopcode=1001 during EXEC2/EXEC3.
- RET (0xF0) -> EXEC1,EXEC2,FETCH with no EXEC3. ADD (0x20) afterwards -> EXEC1,FETCH.
- MUL (0x40), MUL_WAIT=2 -> EXEC1 then MUL_busy=1 for exactly 2 cycles, then FETCH. Rerun with MUL_WAIT=0 -> no MUL_busy.
- mem_ready=0 for 3 cycles in FETCH -> FETCH held, IR_load=0, no EXEC1. Then mem_ready=1 -> IR_load=1, EXEC1 next.
- STP (0xA0) -> HALT=1 held for 20+ cycles with instr_count frozen. nRESET pulse mid-HALT -> FETCH, count=0. With CPU_SEQ_RESUME_EN: resume=1 -> FETCH next cycle.
